// File: rtl/gate_sweep_controller.sv
// Sweeps all 16 vectors through the 4-input gate network and checks its truth table.
// Optional: define SWEEP_ERRCNT_EN to add the err_cnt mismatch counter output.
module gate_sweep_controller #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h5DDD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        gate_a,
  output logic        gate_b,
  output logic        gate_c,
  output logic        gate_d,
  input  logic        gate_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] result,
  output logic        fail_valid,
`ifdef SWEEP_ERRCNT_EN
  output logic [3:0]  fail_idx,
  output logic [4:0]  err_cnt
`else
  output logic [3:0]  fail_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_pass;
  logic        r_fail_valid;
  logic [3:0]  r_fail_idx;
  logic        w_start;
  logic        w_sample;
  logic        w_mis;
  logic        w_drive;
  logic [15:0] w_result_nxt;

`ifdef SWEEP_ERRCNT_EN
  logic [4:0]  r_err_cnt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and capture helpers
  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_mis        = (gate_out != EXPECTED[r_idx]);
    w_result_nxt = r_result;
    w_result_nxt[r_idx] = gate_out;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_start = 1'b1;
          w_next  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort)                 w_next = S_IDLE;
        else if (r_cnt == LP_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (r_idx == 4'd15) w_next = S_DONE;
          else                w_next = S_SETTLE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Vector index, settle timer and captured results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
    end else begin
      if (w_start) begin
        r_idx        <= '0;
        r_cnt        <= '0;
        r_result     <= '0;
        r_pass       <= 1'b0;
        r_fail_valid <= 1'b0;
        r_fail_idx   <= '0;
      end
      if (r_state == S_SETTLE) begin
        if (r_cnt == LP_LAST) r_cnt <= '0;
        else                  r_cnt <= r_cnt + 4'd1;
      end
      if (w_sample) begin
        r_result <= w_result_nxt;
        if (w_mis && !r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_idx   <= r_idx;
        end
        if (r_idx == 4'd15) r_pass <= (w_result_nxt == EXPECTED);
        else                r_idx  <= r_idx + 4'd1;
      end
    end
  end

`ifdef SWEEP_ERRCNT_EN
  // Count mismatching samples, saturating at a full sweep
  always_ff @(posedge clk) begin
    if (rst)                                    r_err_cnt <= '0;
    else if (w_start)                           r_err_cnt <= '0;
    else if (w_sample && w_mis && r_err_cnt != 5'd16)
                                                r_err_cnt <= r_err_cnt + 5'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

  assign w_drive = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign {gate_a, gate_b, gate_c, gate_d} = w_drive ? r_idx : 4'd0;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass;
  assign result     = r_result;
  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: two instances (settle 2 and 1)
// driven against a truth-table gate model with per-vector fault masks.
module tb_gate_sweep_controller;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        start_v [2];
  logic        abort_v [2];
  logic        ga_v    [2];
  logic        gb_v    [2];
  logic        gc_v    [2];
  logic        gd_v    [2];
  logic        gout_v  [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        pass_v  [2];
  logic [15:0] res_v   [2];
  logic        fv_v    [2];
  logic [3:0]  fi_v    [2];
  logic [3:0]  vec_v   [2];
  logic [15:0] mask_v  [2];
`ifdef SWEEP_ERRCNT_EN
  logic [4:0]  ec_v    [2];
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] tt;

  always #5 clk = ~clk;

  gate_sweep_controller #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .gate_a(ga_v[0]), .gate_b(gb_v[0]), .gate_c(gc_v[0]), .gate_d(gd_v[0]),
    .gate_out(gout_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .result(res_v[0]), .fail_valid(fv_v[0]),
`ifdef SWEEP_ERRCNT_EN
    .fail_idx(fi_v[0]), .err_cnt(ec_v[0])
`else
    .fail_idx(fi_v[0])
`endif
  );

  gate_sweep_controller #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .gate_a(ga_v[1]), .gate_b(gb_v[1]), .gate_c(gc_v[1]), .gate_d(gd_v[1]),
    .gate_out(gout_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .result(res_v[1]), .fail_valid(fv_v[1]),
`ifdef SWEEP_ERRCNT_EN
    .fail_idx(fi_v[1]), .err_cnt(ec_v[1])
`else
    .fail_idx(fi_v[1])
`endif
  );

  function automatic logic golden(input logic [3:0] v);
    return ~(((v[3] & v[2]) | ~v[1]) & v[0]);
  endfunction

  assign vec_v[0]  = {ga_v[0], gb_v[0], gc_v[0], gd_v[0]};
  assign vec_v[1]  = {ga_v[1], gb_v[1], gc_v[1], gd_v[1]};
  assign gout_v[0] = golden(vec_v[0]) ^ mask_v[0][vec_v[0]];
  assign gout_v[1] = golden(vec_v[1]) ^ mask_v[1][vec_v[1]];

  function automatic int sc(input int n);
    return (n == 0) ? 2 : 1;
  endfunction

  function automatic int low_bit(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  function automatic int ones(input logic [15:0] m);
    int k = 0;
    for (int i = 0; i < 16; i++) k += int'(m[i]);
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle_all_zero(input int n, input string tag);
    chk(tag, {vec_v[n], busy_v[n], done_v[n], pass_v[n], res_v[n],
              fv_v[n], fi_v[n]}, 32'd0);
`ifdef SWEEP_ERRCNT_EN
    chk({tag, "_err"}, 32'(ec_v[n]), 32'd0);
`endif
  endtask

  task automatic sweep(input int n, input logic [15:0] m, input bit poke);
    int          per;
    int          done_at;
    int          done_cnt;
    int          vec_err;
    logic [15:0] exp_r;
    per      = sc(n) + 1;
    exp_r    = tt ^ m;
    mask_v[n] = m;
    done_at  = -1;
    done_cnt = 0;
    vec_err  = 0;
    @(negedge clk);
    start_v[n] = 1'b1;
    @(posedge clk);
    #1;
    start_v[n] = 1'b0;
    chk("busy_on", 32'(busy_v[n]), 32'd1);
    if (vec_v[n] != 4'd0) vec_err++;
    for (int c = 1; c <= 16 * per + 3; c++) begin
      start_v[n] = (poke && c == 3 * per + 1);
      @(posedge clk);
      #1;
      if (c < 16 * per && int'(vec_v[n]) != c / per) vec_err++;
      if (done_v[n]) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c == done_at + 1) begin
        chk("busy_off", 32'(busy_v[n]), 32'd0);
        chk("vec_idle", 32'(vec_v[n]), 32'd0);
        break;
      end
    end
    start_v[n] = 1'b0;
    chk("done_at", 32'(done_at), 32'(16 * per));
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("vec_seq", 32'(vec_err), 32'd0);
    chk("result", 32'(res_v[n]), 32'(exp_r));
    chk("pass", 32'(pass_v[n]), 32'(m == 16'd0));
    chk("fail_valid", 32'(fv_v[n]), 32'(m != 16'd0));
    chk("fail_idx", 32'(fi_v[n]), 32'(low_bit(m)));
`ifdef SWEEP_ERRCNT_EN
    chk("err_cnt", 32'(ec_v[n]), 32'(ones(m)));
`endif
  endtask

  task automatic abort_at_7(input int n, input logic [15:0] m);
    int per;
    int seen;
    per      = sc(n) + 1;
    mask_v[n] = m;
    seen     = 0;
    @(negedge clk);
    start_v[n] = 1'b1;
    @(posedge clk);
    #1;
    start_v[n] = 1'b0;
    for (int c = 1; c <= 7 * per; c++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_vec7", 32'(vec_v[n]), 32'd7);
    abort_v[n] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[n] = 1'b0;
    chk("abort_busy", 32'(busy_v[n]), 32'd0);
    chk("abort_vec", 32'(vec_v[n]), 32'd0);
    chk("abort_pass", 32'(pass_v[n]), 32'd0);
    chk("abort_part", 32'(res_v[n]), 32'((tt ^ m) & 16'h007F));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      seen += int'(done_v[n]) + int'(busy_v[n]);
    end
    chk("abort_quiet", 32'(seen), 32'd0);
  endtask

  task automatic reset_at_9(input int n, input logic [15:0] m);
    int s;
    s        = sc(n);
    mask_v[n] = m;
    @(negedge clk);
    start_v[n] = 1'b1;
    @(posedge clk);
    #1;
    start_v[n] = 1'b0;
    for (int c = 1; c <= 9 * (s + 1) + s; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pre_vec", 32'(vec_v[n]), 32'd9);
    chk("rst_pre_fv", 32'(fv_v[n]), 32'd1);
    rst_v[n] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[n] = 1'b0;
    check_idle_all_zero(n, "rst_mid");
    @(posedge clk);
    #1;
    chk("rst_stay_idle", 32'(busy_v[n]), 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    tt = '0;
    for (int i = 0; i < 16; i++) tt[i] = golden(4'(i));
    for (int n = 0; n < 2; n++) begin
      rst_v[n]   = 1'b1;
      start_v[n] = 1'b0;
      abort_v[n] = 1'b0;
      mask_v[n]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    check_idle_all_zero(0, "reset0");
    check_idle_all_zero(1, "reset1");

    sweep(0, 16'h0000, 1'b0);
    chk("golden_tt", 32'(res_v[0]), 32'h5DDD);
    sweep(0, ~tt, 1'b0);
    chk("stuck1_res", 32'(res_v[0]), 32'hFFFF);
    abort_at_7(0, 16'h0000);
    sweep(0, 16'h0000, 1'b0);
    sweep(0, 16'h0000, 1'b1);

    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("start_abort", 32'(busy_v[0]), 32'd0);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("start_abort2", 32'(busy_v[0]), 32'd0);

    reset_at_9(0, 16'h0001 | 16'($urandom));

    sweep(1, 16'h0000, 1'b0);
    sweep(1, 16'($urandom), 1'b0);
    abort_at_7(1, 16'($urandom));

    for (int r = 0; r < 8; r++) begin
      m = 16'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) m = '0;
      sweep(r % 2, m, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
